// File: rtl/parity_tx_pkg.sv
// Shared definitions for the parity serial transmitter: FSM state codes
// and the fixed serial-line levels used by both transmitter and checker.
package parity_tx_pkg;

  // FSM state encoding (legacy-compatible 3-bit codes)
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Serial line levels
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/parity_tx_gen.sv
// parity_gen: combinational parity of a W-bit word. With odd = 0 the result
// makes the word plus parity contain an even number of ones; odd = 1 inverts
// it. Kept stand-alone so the receiving/checking side can reuse it.
module parity_gen #(
  parameter int W = 4
) (
  input  logic [W-1:0] data,
  input  logic         odd,
  output logic         parity
);

  assign parity = (^data) ^ odd;

endmodule

// File: rtl/parity_tx.sv
// parity_tx: frames a parallel word as START, DATA (LSB first), PARITY, STOP
// on a serial line that idles high. Each bit lasts BIT_CYCLES clocks.
// Optional feature macro: PARITY_TX_ERR_INJECT_EN adds input inj_err, which
// inverts the parity of the frame accepted while it is high.
//
// Handshake: a word is taken on the rising edge where din_valid && din_ready.
// din_ready is high only in IDLE and in the final clock of STOP; a producer
// may hold din_valid/din for any number of cycles and the word is taken at
// the next ready cycle. All outputs are registered from the next-state
// values so the line changes only on clock edges.
module parity_tx
  import parity_tx_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
`ifdef PARITY_TX_ERR_INJECT_EN
  input  logic              inj_err,
`endif
  output logic              din_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              parity_out,
  output logic              frame_done
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);

  state_t            state;
  state_t            nxt_state;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     nxt_timer;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     nxt_idx;
  logic [DATA_W-1:0] data_q;
  logic              din_par;
  logic              inj_bit;
  logic              accept;
  logic              bit_last;
  logic              nxt_last;
  logic              nxt_level;

  parity_gen #(.W(DATA_W)) u_parity_gen (
    .data   (din),
    .odd    (PARITY_ODD != 0),
    .parity (din_par)
  );

`ifdef PARITY_TX_ERR_INJECT_EN
  assign inj_bit = inj_err;
`else
  assign inj_bit = 1'b0;
`endif

  assign accept   = din_valid & din_ready;
  assign bit_last = (timer == T_LAST);
  assign nxt_last = (nxt_timer == T_LAST);

  // Next-state, bit timer and data index
  always_comb begin
    nxt_state = state;
    nxt_timer = bit_last ? '0 : timer + TW'(1);
    nxt_idx   = idx;
    case (state)
      ST_IDLE: begin
        nxt_timer = '0;
        if (accept) nxt_state = ST_START;
      end
      ST_START: begin
        if (bit_last) begin
          nxt_state = ST_DATA;
          nxt_idx   = '0;
        end
      end
      ST_DATA: begin
        if (bit_last) begin
          if (idx == I_LAST) nxt_state = ST_PARITY;
          else               nxt_idx   = idx + IW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_last) nxt_state = ST_STOP;
      end
      ST_STOP: begin
        if (bit_last) nxt_state = accept ? ST_START : ST_IDLE;
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_timer = '0;
      end
    endcase
  end

  // Line level for the upcoming cycle; data_q and parity_out are stable
  // whenever the next state reads them
  always_comb begin
    nxt_level = IDLE_LEVEL;
    case (nxt_state)
      ST_START:  nxt_level = START_BIT;
      ST_DATA:   nxt_level = data_q[nxt_idx];
      ST_PARITY: nxt_level = parity_out;
      ST_STOP:   nxt_level = STOP_BIT;
      default:   nxt_level = IDLE_LEVEL;
    endcase
  end

  // State, counters, captured word and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      idx        <= '0;
      data_q     <= '0;
      tx_out     <= IDLE_LEVEL;
      tx_busy    <= 1'b0;
      din_ready  <= 1'b0;
      frame_done <= 1'b0;
      parity_out <= 1'b0;
    end else begin
      state      <= nxt_state;
      timer      <= nxt_timer;
      idx        <= nxt_idx;
      tx_out     <= nxt_level;
      tx_busy    <= (nxt_state != ST_IDLE);
      frame_done <= (nxt_state == ST_STOP) && nxt_last;
      din_ready  <= (nxt_state == ST_IDLE) || ((nxt_state == ST_STOP) && nxt_last);
      if (accept) begin
        data_q     <= din;
        parity_out <= din_par ^ inj_bit;
      end
    end
  end

endmodule

// File: tb/tb_parity_tx.sv
// Bench for parity_tx: three instances (even/BIT_CYCLES=1, odd/BIT_CYCLES=1,
// even/BIT_CYCLES=3) share data and reset; one is selected at a time.
// Expected line waveforms come from a frame model built from the bit rules.
module tb_parity_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [2:0] vld;
  logic       inj;
  wire  [2:0] rdy;
  wire  [2:0] tx;
  wire  [2:0] busy;
  wire  [2:0] par;
  wire  [2:0] done;

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  parity_tx #(.DATA_W(4), .BIT_CYCLES(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .din(din), .din_valid(vld[0]),
`ifdef PARITY_TX_ERR_INJECT_EN
    .inj_err(inj),
`endif
    .din_ready(rdy[0]), .tx_out(tx[0]), .tx_busy(busy[0]),
    .parity_out(par[0]), .frame_done(done[0]));

  parity_tx #(.DATA_W(4), .BIT_CYCLES(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .din(din), .din_valid(vld[1]),
`ifdef PARITY_TX_ERR_INJECT_EN
    .inj_err(inj),
`endif
    .din_ready(rdy[1]), .tx_out(tx[1]), .tx_busy(busy[1]),
    .parity_out(par[1]), .frame_done(done[1]));

  parity_tx #(.DATA_W(4), .BIT_CYCLES(3), .PARITY_ODD(0)) u_slow (
    .clk(clk), .rst(rst), .din(din), .din_valid(vld[2]),
`ifdef PARITY_TX_ERR_INJECT_EN
    .inj_err(inj),
`endif
    .din_ready(rdy[2]), .tx_out(tx[2]), .tx_busy(busy[2]),
    .parity_out(par[2]), .frame_done(done[2]));

  function automatic int bc_of(input int s);
    return (s == 2) ? 3 : 1;
  endfunction

  function automatic bit odd_of(input int s);
    return (s == 1);
  endfunction

  function automatic bit inj_eff(input bit i);
`ifdef PARITY_TX_ERR_INJECT_EN
    return i;
`else
    return 1'b0;
`endif
  endfunction

  // Parity from a count of ones: even parity makes the total count even
  function automatic bit ref_parity(input logic [3:0] w, input bit odd, input bit i);
    int ones = 0;
    for (int b = 0; b < 4; b++) ones += int'(w[b]);
    return ((ones % 2) == 1) ^ odd ^ i;
  endfunction

  // Expected line level of every clock of one frame
  task automatic build_frame(input logic [3:0] w, input bit p, input int bc);
    logic bits[$];
    exp_q.delete();
    bits.push_back(1'b0);
    for (int b = 0; b < 4; b++) bits.push_back(w[b]);
    bits.push_back(p);
    bits.push_back(1'b1);
    foreach (bits[n]) for (int r = 0; r < bc; r++) exp_q.push_back(bits[n]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for din_ready on the selected instance
  task automatic wait_ready;
    int n = 0;
    while (rdy[sel] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", rdy[sel], 1);
  endtask

  // Present a word and let it be accepted on the next edge
  task automatic offer(input logic [3:0] w, input bit i);
    wait_ready();
    din      = w;
    inj      = i;
    vld[sel] = 1'b1;
    tick();
  endtask

  // Check a whole frame that started with the last edge; optionally hold the
  // next word valid throughout (scrambled while not ready) for back-to-back
  task automatic check_frame(input logic [3:0] w, input bit i, input bit chain,
                             input logic [3:0] nw, input bit ni);
    int len;
    bit p;
    p   = ref_parity(w, odd_of(sel), inj_eff(i));
    build_frame(w, p, bc_of(sel));
    len = exp_q.size();
    vld[sel] = chain;
    chk("parity_out", par[sel], p);
    for (int k = 0; k < len; k++) begin
      if (k == len - 1 && chain) begin
        din = nw;
        inj = ni;
      end else begin
        din = 4'($urandom);
        inj = 1'($urandom);
      end
      chk($sformatf("tx_out[%0d]", k), tx[sel], exp_q[k]);
      chk($sformatf("tx_busy[%0d]", k), busy[sel], 1);
      chk($sformatf("frame_done[%0d]", k), done[sel], (k == len - 1));
      chk($sformatf("din_ready[%0d]", k), rdy[sel], (k == len - 1));
      tick();
    end
    vld[sel] = 1'b0;
  endtask

  // Idle cycles: line high, not busy, ready
  task automatic check_idle(input int n);
    for (int k = 0; k < n; k++) begin
      chk("idle_tx", tx[sel], 1);
      chk("idle_busy", busy[sel], 0);
      chk("idle_ready", rdy[sel], 1);
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] w;
    logic [3:0] nw;
    bit         i;
    bit         ni;
    bit         c;

    rst = 1'b1;
    vld = '0;
    din = '0;
    inj = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      chk("rst_tx", tx[s], 1);
      chk("rst_busy", busy[s], 0);
      chk("rst_ready", rdy[s], 0);
      chk("rst_done", done[s], 0);
      chk("rst_par", par[s], 0);
    end
    rst = 1'b0;
    tick();
    chk("ready_after_reset", rdy[0], 1);

    // 1011 even: 0,1,1,0,1,1,1 with parity_out 1
    sel = 0;
    offer(4'b1011, 1'b0);
    check_frame(4'b1011, 1'b0, 1'b0, 4'h0, 1'b0);
    check_idle(2);

    // 0000 gives parity 0 even, 1 odd
    offer(4'b0000, 1'b0);
    check_frame(4'b0000, 1'b0, 1'b0, 4'h0, 1'b0);
    sel = 1;
    offer(4'b0000, 1'b0);
    check_frame(4'b0000, 1'b0, 1'b0, 4'h0, 1'b0);
    check_idle(1);

    // Back-to-back A then 5 with valid held high
    sel = 0;
    offer(4'hA, 1'b0);
    check_frame(4'hA, 1'b0, 1'b1, 4'h5, 1'b0);
    check_frame(4'h5, 1'b0, 1'b0, 4'h0, 1'b0);
    check_idle(1);

    // Three clocks per bit: 21-clock frame
    sel = 2;
    offer(4'b1011, 1'b0);
    check_frame(4'b1011, 1'b0, 1'b0, 4'h0, 1'b0);
    check_idle(1);

    // Parity error injection then a clean frame
    sel = 0;
    offer(4'b1011, 1'b1);
    check_frame(4'b1011, 1'b1, 1'b0, 4'h0, 1'b0);
    offer(4'b1011, 1'b0);
    check_frame(4'b1011, 1'b0, 1'b0, 4'h0, 1'b0);

    // Random words, instances, chaining and idle gaps
    for (int t = 0; t < 12; t++) begin
      sel = $urandom_range(0, 2);
      w   = 4'($urandom);
      i   = 1'($urandom);
      offer(w, i);
      c = 1'b1;
      while (c) begin
        c  = ($urandom_range(0, 2) == 0);
        nw = 4'($urandom);
        ni = 1'($urandom);
        check_frame(w, i, c, nw, ni);
        w = nw;
        i = ni;
      end
      check_idle($urandom_range(0, 3));
    end

    // Reset in the middle of DATA aborts the frame
    sel = 0;
    offer(4'b0110, 1'b0);
    vld = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_tx", tx[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_ready", rdy[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_par", par[0], 0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_ready_release", rdy[0], 1);
    for (int k = 0; k < 8; k++) begin
      chk("abort_no_resume_tx", tx[0], 1);
      chk("abort_no_done", done[0], 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_tx.md
PARITY_TX -- requirements
Module: parity_tx

Interface
REQ-001 SHALL provide parameter DATA_W, default 4, data bits per frame (legal 1..16).
REQ-002 SHALL provide parameter BIT_CYCLES, default 1, clocks each serial bit is held (legal >= 1).
REQ-003 SHALL provide parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL provide port clk  input  1  rising-edge clock.
REQ-006 SHALL provide port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL provide port din  input  DATA_W  parallel data word to transmit.
REQ-008 SHALL provide port din_valid  input  1  din is valid this cycle.
REQ-009 SHALL provide port din_ready  output  1  block accepts din this cycle.
REQ-010 SHALL provide port tx_out  output  1  serial line, idle high.
REQ-011 SHALL provide port tx_busy  output  1  frame in progress (START..STOP).
REQ-012 SHALL provide port parity_out  output  1  parity bit of the current/last frame, registered.
REQ-013 SHALL provide port frame_done  output  1  one-cycle pulse in the final clock of STOP.

Function
REQ-014 SHALL accept a word on the rising edge where din_valid && din_ready, capturing din and its parity into internal registers.
REQ-015 SHALL assert din_ready in IDLE and in the final clock of STOP only; din_ready SHALL be 0 in all other cycles.
REQ-016 SHALL implement FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE, with STOP -> START directly when a word is accepted in STOP's final clock.
REQ-017 SHALL hold every frame bit for exactly BIT_CYCLES clocks via a bit timer; DATA SHALL use a bit index counter 0..DATA_W-1.
REQ-018 SHALL drive tx_out = 1 in IDLE, 0 in START, din[i] LSB first in DATA, parity in PARITY, 1 in STOP.
REQ-019 SHALL compute parity = XOR of all DATA_W bits, inverted when PARITY_ODD = 1, so that the data bits XOR parity = PARITY_ODD.
REQ-020 SHALL produce the start bit on the clock edge after acceptance; total frame length SHALL be (DATA_W+3)*BIT_CYCLES clocks.
REQ-021 SHALL ignore din and din_valid while din_ready = 0; a held word SHALL not be lost and SHALL be accepted at the next ready cycle.
REQ-022 SHALL register tx_out so it is glitch-free; tx_busy SHALL be 1 exactly in START, DATA, PARITY and STOP.

Reset
REQ-023 SHALL on rst = 1 force state IDLE, tx_out = 1, tx_busy = 0, din_ready = 0, frame_done = 0, parity_out = 0, and clear the counters, all asynchronously.
REQ-024 SHALL abort any frame in progress when rst is asserted mid-frame, with no frame_done pulse, and SHALL NOT resume it after reset.
REQ-025 SHALL assert din_ready on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL, with PARITY_TX_ERR_INJECT_EN defined, add input port inj_err (1 bit) sampled at acceptance; when it is 1, the transmitted parity bit and parity_out SHALL be inverted for that frame only.
REQ-027 SHALL, without PARITY_TX_ERR_INJECT_EN, omit the inj_err port and always transmit correct parity.

Structure
REQ-028 SHALL place the FSM state enumeration and the line-level constants IDLE_LEVEL = 1, START_BIT = 0 and STOP_BIT = 1 in shared package parity_tx_pkg.
REQ-029 SHALL instantiate one combinational sub-module parity_gen (XOR reduction plus odd select); the same sub-module SHALL be reusable by the checker side.

Verification
REQ-030 SHALL cover DATA_W=4, BIT_CYCLES=1, din=4'b1011 accepted -> tx_out 0,1,1,0,1,1,1 on the following 7 clocks, parity_out=1, frame_done on clock 7.
REQ-031 SHALL cover din=4'b0000 -> parity bit 0; with PARITY_ODD=1 and din=4'b0000 -> parity bit 1.
REQ-032 SHALL cover din_valid held high with 4'hA then 4'h5 -> second START immediately follows first STOP, with no idle cycle between them.
REQ-033 SHALL cover BIT_CYCLES=3 -> each bit held 3 clocks, frame 21 clocks, din_ready low for clocks 1..20.
REQ-034 SHALL cover rst pulsed during DATA -> tx_out = 1 immediately, no frame_done, din_ready = 1 one clock after release.
REQ-035 SHALL cover, with PARITY_TX_ERR_INJECT_EN, inj_err=1 and din=4'b1011 -> parity bit 0, and the next frame with inj_err=0 -> correct parity.
